pll_loop_filter: RTL and testbench

Digital PI loop filter and lock controller for the ring-oscillator PLL, clocked by the reference clock. It sits directly upstream of the DCO. Each reference cycle it consumes a signed phase/frequency error word from the detector and produces the DCO control code. It runs a gear-shifted acquire/track state machine, honours the PLL brake input, and reports lock.

---
 rtl/pll_loop_filter.sv | 158 +++++++++++++++
 tb/tb_pll_loop_filter.sv | 264 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/pll_loop_filter.sv
// Digital PI loop filter and lock controller for the ring-oscillator PLL.
// Runs in the reference clock domain: one error sample in, one DCO code out.
// Gear-shifted ACQ/TRACK gains, a HOLD state driven by brake, and a lock flag.
module pll_loop_filter #(
    parameter int unsigned ERR_W     = 8,
    parameter int unsigned CODE_W    = 10,
    parameter int unsigned FRAC      = 8,
    parameter int unsigned CODE_INIT = 512,
    parameter int unsigned KP_ACQ_SH = 1,
    parameter int unsigned KI_ACQ_SH = 3,
    parameter int unsigned KP_TRK_SH = 3,
    parameter int unsigned KI_TRK_SH = 6,
    parameter int unsigned LOCK_TOL  = 2,
    parameter int unsigned LOCK_CNT  = 16
) (
    input  logic              refclk,
    input  logic              resetn,
    input  logic              brake,
    input  logic              err_valid,
    input  logic [ERR_W-1:0]  err,
    output logic [CODE_W-1:0] dco_code,
    output logic              code_sat,
    output logic              lock
);

    // Accumulator width and signed math width (two guard bits over the widest operand).
    localparam int unsigned AW = CODE_W + FRAC;
    localparam int unsigned MW = ((CODE_W > ERR_W) ? CODE_W : ERR_W) + FRAC + 2;
    localparam int unsigned CW = $clog2(LOCK_CNT + 1);

    typedef enum logic [1:0] {StAcq, StTrack, StHold} state_e;

    state_e            state_q;
    logic [AW-1:0]     acc_q;
    logic [CW-1:0]     cnt_q;

    logic [ERR_W:0]    err_sx;
    logic [ERR_W:0]    err_abs;
    logic [31:0]       err_mag;
    logic              in_tol;
    logic              out_trk;
    logic [CW-1:0]     cnt_inc;

    logic signed [MW-1:0] err_w;
    logic signed [MW-1:0] i_term;
    logic signed [MW-1:0] p_term;
    logic signed [MW-1:0] acc_sum;
    logic signed [MW-1:0] out_sum;
    logic signed [MW-1:0] out_sh;
    logic [AW-1:0]        acc_n;
    logic [CODE_W-1:0]    code_n;
    logic                 acc_clamp;
    logic                 code_clamp;

    // Error magnitude and lock-window classification; -2^(ERR_W-1) maps to +2^(ERR_W-1).
    always_comb begin
        err_sx  = {err[ERR_W-1], err};
        err_abs = err[ERR_W-1] ? (~err_sx + 1'b1) : err_sx;
        err_mag = 32'(err_abs);
        in_tol  = (err_mag <= LOCK_TOL);
        out_trk = (err_mag > 4 * LOCK_TOL);
        cnt_inc = (cnt_q == CW'(LOCK_CNT)) ? cnt_q : cnt_q + CW'(1);
    end

    // PI datapath: gains selected by the current state, both clamps evaluated here.
    always_comb begin
        err_w = MW'(signed'(err));
        if (state_q == StTrack) begin
            i_term = err_w <<< (FRAC - KI_TRK_SH);
            p_term = err_w <<< (FRAC - KP_TRK_SH);
        end else begin
            i_term = err_w <<< (FRAC - KI_ACQ_SH);
            p_term = err_w <<< (FRAC - KP_ACQ_SH);
        end

        acc_sum   = signed'(MW'(acc_q)) + i_term;
        acc_clamp = 1'b0;
        if (acc_sum[MW-1]) begin
            acc_n     = '0;
            acc_clamp = 1'b1;
        end else if (acc_sum[MW-2:AW] != '0) begin
            acc_n     = '1;
            acc_clamp = 1'b1;
        end else begin
            acc_n = acc_sum[AW-1:0];
        end

        // Arithmetic shift floors toward minus infinity, matching the code quantiser.
        out_sum    = signed'(MW'(acc_n)) + p_term;
        out_sh     = out_sum >>> FRAC;
        code_clamp = 1'b0;
        if (out_sh[MW-1]) begin
            code_n     = '0;
            code_clamp = 1'b1;
        end else if (out_sh[MW-2:CODE_W] != '0) begin
            code_n     = '1;
            code_clamp = 1'b1;
        end else begin
            code_n = out_sh[CODE_W-1:0];
        end
    end

    // Loop state, lock counter and registered outputs; brake overrides everything.
    always_ff @(posedge refclk or negedge resetn) begin
        if (!resetn) begin
            state_q  <= StAcq;
            acc_q    <= {CODE_W'(CODE_INIT), {FRAC{1'b0}}};
            dco_code <= CODE_W'(CODE_INIT);
            code_sat <= 1'b0;
            lock     <= 1'b0;
            cnt_q    <= '0;
        end else if (brake) begin
            state_q <= StHold;
            lock    <= 1'b0;
            cnt_q   <= '0;
        end else begin
            unique case (state_q)
                StHold: begin
                    state_q <= StAcq;
                end
                StAcq: begin
                    if (err_valid) begin
                        acc_q    <= acc_n;
                        dco_code <= code_n;
                        code_sat <= acc_clamp | code_clamp;
                        if (in_tol) begin
                            cnt_q <= cnt_inc;
                            if (cnt_inc == CW'(LOCK_CNT)) begin
                                state_q <= StTrack;
                                lock    <= 1'b1;
                            end
                        end else begin
                            cnt_q <= '0;
                        end
                    end
                end
                StTrack: begin
                    if (err_valid) begin
                        acc_q    <= acc_n;
                        dco_code <= code_n;
                        code_sat <= acc_clamp | code_clamp;
                        if (out_trk) begin
                            state_q <= StAcq;
                            lock    <= 1'b0;
                            cnt_q   <= '0;
                        end else if (!in_tol) begin
                            cnt_q <= '0;
                        end
                    end
                end
                default: begin
                    state_q <= StAcq;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_pll_loop_filter.sv
// Self-checking bench for pll_loop_filter: vector table, directed corner
// sequences, and randomized traffic against an arithmetic reference model.
module tb_pll_loop_filter;

    localparam int  FRAC      = 8;
    localparam int  KP_ACQ    = 1;
    localparam int  KI_ACQ    = 3;
    localparam int  KP_TRK    = 3;
    localparam int  KI_TRK    = 6;
    localparam int  TOL       = 2;
    localparam int  NLOCK     = 16;
    localparam longint ACCMAX = (longint'(1) << 18) - 1;
    localparam int  CODEMAX   = 1023;

    logic       refclk = 1'b0;
    logic       resetn;
    logic       brake;
    logic       err_valid;
    logic [7:0] err;
    logic [9:0] dco_code;
    logic       code_sat;
    logic       lock;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model state: 0 = acquire, 1 = track, 2 = hold.
    int     m_state;
    longint m_acc;
    int     m_code;
    bit     m_sat;
    bit     m_lock;
    int     m_cnt;

    typedef struct {
        bit b;
        bit v;
        int e;
        int code;
        bit sat;
        bit lk;
    } vec_t;

    vec_t tbl[9];

    pll_loop_filter dut (
        .refclk    (refclk),
        .resetn    (resetn),
        .brake     (brake),
        .err_valid (err_valid),
        .err       (err),
        .dco_code  (dco_code),
        .code_sat  (code_sat),
        .lock      (lock)
    );

    always #5 refclk = ~refclk;

    task automatic check(input string name, input longint act, input longint exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic model_reset();
        m_state = 0;
        m_acc   = longint'(512) * 256;
        m_code  = 512;
        m_sat   = 0;
        m_lock  = 0;
        m_cnt   = 0;
    endtask

    function automatic longint floor_div(input longint a, input longint d);
        if (a >= 0) return a / d;
        return -((-a + d - 1) / d);
    endfunction

    task automatic model_step(input bit b, input bit v, input int e);
        int     mag;
        int     ki;
        int     kp;
        longint a;
        longint s;
        longint c;
        bit     sat;
        mag = (e < 0) ? -e : e;
        if (b) begin
            m_state = 2;
            m_lock  = 0;
            m_cnt   = 0;
        end else if (m_state == 2) begin
            m_state = 0;
        end else if (v) begin
            ki  = (m_state == 1) ? KI_TRK : KI_ACQ;
            kp  = (m_state == 1) ? KP_TRK : KP_ACQ;
            sat = 0;
            a   = m_acc + longint'(e) * (longint'(1) << (FRAC - ki));
            if (a < 0) begin a = 0; sat = 1; end
            if (a > ACCMAX) begin a = ACCMAX; sat = 1; end
            s = a + longint'(e) * (longint'(1) << (FRAC - kp));
            c = floor_div(s, 256);
            if (c < 0) begin c = 0; sat = 1; end
            if (c > CODEMAX) begin c = CODEMAX; sat = 1; end
            m_acc  = a;
            m_code = int'(c);
            m_sat  = sat;
            if (m_state == 0) begin
                if (mag <= TOL) m_cnt = (m_cnt < NLOCK) ? m_cnt + 1 : NLOCK;
                else m_cnt = 0;
                if (m_cnt == NLOCK) begin
                    m_state = 1;
                    m_lock  = 1;
                end
            end else begin
                if (mag > 4 * TOL) begin
                    m_state = 0;
                    m_lock  = 0;
                    m_cnt   = 0;
                end else if (mag > TOL) begin
                    m_cnt = 0;
                end
            end
        end
    endtask

    // Drive one cycle, advance the model on the edge, sample 1 time unit later.
    task automatic step(input bit b, input bit v, input int e);
        brake     = b;
        err_valid = v;
        err       = 8'(e);
        @(posedge refclk);
        model_step(b, v, e);
        #1;
    endtask

    task automatic check_model(input string tag);
        check({tag, " code"}, dco_code, m_code);
        check({tag, " sat"}, code_sat, m_sat);
        check({tag, " lock"}, lock, m_lock);
    endtask

    // Asynchronous reset: outputs must return without any clock edge.
    task automatic do_reset(input string tag);
        resetn    = 1'b0;
        brake     = 1'b0;
        err_valid = 1'b0;
        err       = '0;
        #1;
        model_reset();
        check({tag, " rst code"}, dco_code, 512);
        check({tag, " rst sat"}, code_sat, 0);
        check({tag, " rst lock"}, lock, 0);
        @(negedge refclk);
        resetn = 1'b1;
    endtask

    initial begin
        int e;
        int r;

        tbl[0] = '{0, 1,  8, 517, 0, 0};
        tbl[1] = '{0, 0,  0, 517, 0, 0};
        tbl[2] = '{0, 0,  0, 517, 0, 0};
        tbl[3] = '{1, 1, 50, 517, 0, 0};
        tbl[4] = '{0, 0,  0, 517, 0, 0};
        tbl[5] = '{0, 1,  8, 518, 0, 0};
        tbl[6] = '{0, 1, -8, 509, 0, 0};
        tbl[7] = '{0, 1, -1, 512, 0, 0};
        tbl[8] = '{0, 1,  0, 512, 0, 0};

        resetn    = 1'b0;
        brake     = 1'b0;
        err_valid = 1'b0;
        err       = '0;
        #12;
        do_reset("init");

        for (int k = 0; k < 9; k++) begin
            step(tbl[k].b, tbl[k].v, tbl[k].e);
            check($sformatf("tbl%0d code", k), dco_code, tbl[k].code);
            check($sformatf("tbl%0d sat", k), code_sat, tbl[k].sat);
            check($sformatf("tbl%0d lock", k), lock, tbl[k].lk);
        end

        // Mid-cycle asynchronous reset after moving away from the init code.
        step(0, 1, 40);
        #2;
        do_reset("async");

        // Lock after exactly sixteen in-lock samples, unlock on a large error.
        for (int k = 0; k < 16; k++) begin
            step(0, 1, 1);
            check($sformatf("lock seq %0d", k), lock, (k == 15) ? 1 : 0);
        end
        check_model("locked");
        step(0, 1, 9);
        check("unlock lock", lock, 0);
        check_model("unlock");

        // An out-of-window sample at count fifteen restarts the count.
        do_reset("cnt");
        for (int k = 0; k < 15; k++) step(0, 1, 1);
        step(0, 1, 3);
        for (int k = 0; k < 15; k++) step(0, 1, 1);
        check("cnt cleared lock", lock, 0);
        step(0, 1, 1);
        check("cnt relock", lock, 1);

        // Brake while locked, then release and resume with acquire gains.
        step(1, 1, 1);
        check("brake lock", lock, 0);
        check_model("brake");
        step(0, 0, 0);
        check_model("release");
        step(0, 1, 8);
        check_model("post brake");

        // Track-gain step from the reset code.
        do_reset("trk");
        for (int k = 0; k < 16; k++) step(0, 1, 0);
        check("trk lock", lock, 1);
        step(0, 1, 8);
        check("trk code", dco_code, 513);
        check("trk sat", code_sat, 0);
        check("trk lock hold", lock, 1);

        // Upper saturation, accumulator clamp, lower saturation, recovery.
        do_reset("sat");
        for (int k = 0; k < 40; k++) step(0, 1, 127);
        check("sat hi code", dco_code, 1023);
        check("sat hi flag", code_sat, 1);
        step(0, 1, -1);
        check("acc clamp code", dco_code, 1023);
        check("acc clamp flag", code_sat, 0);
        for (int k = 0; k < 80; k++) step(0, 1, -128);
        check("sat lo code", dco_code, 0);
        check("sat lo flag", code_sat, 1);
        step(0, 1, 1);
        check("recover code", dco_code, 0);
        check("recover flag", code_sat, 0);

        // Randomized traffic, mostly small errors so lock is reached regularly.
        do_reset("rand");
        for (int k = 0; k < 3000; k++) begin
            r = int'($urandom_range(0, 99));
            if (r == 0) begin
                #2;
                do_reset("rand mid");
            end else begin
                if ($urandom_range(0, 9) < 6) e = int'($urandom_range(0, 6)) - 3;
                else e = int'($urandom_range(0, 255)) - 128;
                step(r < 5, $urandom_range(0, 9) < 7, e);
                check_model($sformatf("rand %0d", k));
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
